// File: rtl/dram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dram_arbiter
// Purpose  : Two-port round-robin arbiter in front of the DRAM user interface.
//            Port 0 is the instruction-fetch refill path, port 1 is the
//            data-cache refill/writeback path. One command in flight at a
//            time, at most one outstanding read; read data returns to the
//            port that issued the read.
// Config   : DRAM_ARB_TIMEOUT_EN - enables a read watchdog in RD_WAIT. When
//            it expires, the owner gets rvalid with zero data plus rd_err.
//            Without it, RD_WAIT waits indefinitely and rd_err stays 0.
// Ports    : clk_166_67_mhz, dram_rstx_async (async, active-low)
//            m0_* / m1_*  : requester side (ren, wen, addr, wdata, wmask in;
//                           ack, rdata, rvalid out)
//            rd_err       : timed-out read response pulse
//            dram_*       : DRAM user interface (command out; busy,
//                           init_calib_complete, rdata, rdata_valid in)
// Revision : 1.0 - initial release
// ============================================================================
module dram_arbiter #(
  parameter int ADDR_W         = 27,
  parameter int DATA_W         = 128,
  parameter int MASK_W         = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk_166_67_mhz,
  input  logic              dram_rstx_async,
  input  logic              m0_ren,
  input  logic              m1_ren,
  input  logic              m0_wen,
  input  logic              m1_wen,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [MASK_W-1:0] m0_wmask,
  input  logic [MASK_W-1:0] m1_wmask,
  output logic              m0_ack,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic              rd_err,
  output logic              dram_ren,
  output logic              dram_wen,
  output logic [ADDR_W-1:0] dram_addr,
  output logic [DATA_W-1:0] dram_wdata,
  output logic [MASK_W-1:0] dram_wmask,
  input  logic              dram_busy,
  input  logic              dram_init_calib_complete,
  input  logic [DATA_W-1:0] dram_rdata,
  input  logic              dram_rdata_valid
);

  localparam logic [1:0] S_CALIB   = 2'd0;
  localparam logic [1:0] S_IDLE    = 2'd1;
  localparam logic [1:0] S_ISSUE   = 2'd2;
  localparam logic [1:0] S_RD_WAIT = 2'd3;

  logic [1:0] r_state;
  logic       r_ptr;      // port holding round-robin priority
  logic       r_owner;    // port that owns the command in flight
  logic       r_is_read;  // command in flight is a read

`ifdef DRAM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] r_wait_cnt;
`endif

  // Grant selection: priority port if it requests, otherwise the other one.
  logic w_req0;
  logic w_req1;
  logic w_any_req;
  logic w_sel;
  logic w_sel_wen;

  assign w_req0    = m0_ren | m0_wen;
  assign w_req1    = m1_ren | m1_wen;
  assign w_any_req = w_req0 | w_req1;
  assign w_sel     = r_ptr ? w_req1 : ~w_req0;
  // A port raising both ren and wen is treated as a write.
  assign w_sel_wen = w_sel ? m1_wen : m0_wen;

  always_ff @(posedge clk_166_67_mhz or negedge dram_rstx_async) begin
    if (!dram_rstx_async) begin
      r_state    <= S_CALIB;
      r_ptr      <= 1'b0;
      r_owner    <= 1'b0;
      r_is_read  <= 1'b0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      m0_rvalid  <= 1'b0;
      m1_rvalid  <= 1'b0;
      rd_err     <= 1'b0;
      dram_ren   <= 1'b0;
      dram_wen   <= 1'b0;
      dram_addr  <= '0;
      dram_wdata <= '0;
      dram_wmask <= '0;
`ifdef DRAM_ARB_TIMEOUT_EN
      r_wait_cnt <= '0;
`endif
    end else begin
      // Pulse outputs default low every cycle.
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      rd_err    <= 1'b0;

      case (r_state)
        S_CALIB: begin
          if (dram_init_calib_complete) begin
            r_state <= S_IDLE;
          end
        end

        S_IDLE: begin
          if (!dram_init_calib_complete) begin
            r_state <= S_CALIB;
          end else if (w_any_req) begin
            r_owner    <= w_sel;
            r_is_read  <= ~w_sel_wen;
            dram_ren   <= ~w_sel_wen;
            dram_wen   <= w_sel_wen;
            dram_addr  <= w_sel ? m1_addr  : m0_addr;
            dram_wdata <= w_sel ? m1_wdata : m0_wdata;
            dram_wmask <= w_sel ? m1_wmask : m0_wmask;
            r_state    <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          // Command fields stay put until the DRAM takes the command.
          if (!dram_busy) begin
            dram_ren <= 1'b0;
            dram_wen <= 1'b0;
            if (r_owner) begin
              m1_ack <= 1'b1;
            end else begin
              m0_ack <= 1'b1;
            end
            r_ptr   <= ~r_owner;
            r_state <= r_is_read ? S_RD_WAIT : S_IDLE;
`ifdef DRAM_ARB_TIMEOUT_EN
            r_wait_cnt <= '0;
`endif
          end
        end

        S_RD_WAIT: begin
          if (dram_rdata_valid) begin
            if (r_owner) begin
              m1_rdata  <= dram_rdata;
              m1_rvalid <= 1'b1;
            end else begin
              m0_rdata  <= dram_rdata;
              m0_rvalid <= 1'b1;
            end
            r_state <= S_IDLE;
          end
`ifdef DRAM_ARB_TIMEOUT_EN
          else if (r_wait_cnt == c_timeout_last) begin
            // Complete the read with zero data so the requester never hangs.
            if (r_owner) begin
              m1_rdata  <= '0;
              m1_rvalid <= 1'b1;
            end else begin
              m0_rdata  <= '0;
              m0_rvalid <= 1'b1;
            end
            rd_err  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
`endif
        end

        default: r_state <= S_CALIB;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dram_arbiter
// Purpose  : Directed self-checking bench for dram_arbiter. Inputs are driven
//            and outputs sampled 1 ns after the rising clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dram_arbiter;

  localparam int ADDR_W = 27;
  localparam int DATA_W = 128;
  localparam int MASK_W = 16;

  logic              clk_166_67_mhz = 1'b0;
  logic              dram_rstx_async = 1'b0;
  logic              m0_ren = 0, m1_ren = 0, m0_wen = 0, m1_wen = 0;
  logic [ADDR_W-1:0] m0_addr = '0, m1_addr = '0;
  logic [DATA_W-1:0] m0_wdata = '0, m1_wdata = '0;
  logic [MASK_W-1:0] m0_wmask = '0, m1_wmask = '0;
  logic              m0_ack, m1_ack, m0_rvalid, m1_rvalid, rd_err;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              dram_ren, dram_wen;
  logic [ADDR_W-1:0] dram_addr;
  logic [DATA_W-1:0] dram_wdata;
  logic [MASK_W-1:0] dram_wmask;
  logic              dram_busy = 1'b0;
  logic              dram_init_calib_complete = 1'b0;
  logic [DATA_W-1:0] dram_rdata = '0;
  logic              dram_rdata_valid = 1'b0;

  int errors = 0;
  int checks = 0;

  always #3 clk_166_67_mhz = ~clk_166_67_mhz;

  dram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_166_67_mhz(clk_166_67_mhz), .dram_rstx_async(dram_rstx_async),
    .m0_ren(m0_ren), .m1_ren(m1_ren), .m0_wen(m0_wen), .m1_wen(m1_wen),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_wmask(m0_wmask), .m1_wmask(m1_wmask),
    .m0_ack(m0_ack), .m1_ack(m1_ack),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid), .rd_err(rd_err),
    .dram_ren(dram_ren), .dram_wen(dram_wen), .dram_addr(dram_addr),
    .dram_wdata(dram_wdata), .dram_wmask(dram_wmask),
    .dram_busy(dram_busy), .dram_init_calib_complete(dram_init_calib_complete),
    .dram_rdata(dram_rdata), .dram_rdata_valid(dram_rdata_valid)
  );

  task automatic step();
    @(posedge clk_166_67_mhz);
    #1;
  endtask

  // Reset, raise calibration, and leave the DUT in IDLE.
  task automatic do_reset();
    {m0_ren, m1_ren, m0_wen, m1_wen} = 4'b0;
    dram_busy = 1'b0;
    dram_rdata_valid = 1'b0;
    dram_init_calib_complete = 1'b0;
    dram_rstx_async = 1'b0;
    step();
    step();
    dram_rstx_async = 1'b1;
    dram_init_calib_complete = 1'b1;
    step();
  endtask

  // Advance until a DRAM command appears (bounded).
  task automatic wait_cmd(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (dram_ren || dram_wen) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    dram_rstx_async = 1'b0;
    step();
    step();
    checks++;
    if ({m0_ack, m1_ack, m0_rvalid, m1_rvalid, rd_err, dram_ren, dram_wen} !== 7'b0) begin
      errors++;
      $display("FAIL reset_pulses: got %b expected 0",
               {m0_ack, m1_ack, m0_rvalid, m1_rvalid, rd_err, dram_ren, dram_wen});
    end
    checks++;
    if (dram_addr !== '0 || dram_wdata !== '0 || dram_wmask !== '0) begin
      errors++;
      $display("FAIL reset_cmd_fields: addr=%h wdata=%h wmask=%h expected 0",
               dram_addr, dram_wdata, dram_wmask);
    end
    checks++;
    if (m0_rdata !== '0 || m1_rdata !== '0) begin
      errors++;
      $display("FAIL reset_rdata: m0=%h m1=%h expected 0", m0_rdata, m1_rdata);
    end
  endtask

  task automatic test_calib();
    bit bad = 1'b0;
    dram_rstx_async = 1'b1;
    m0_ren = 1'b1;
    m0_addr = 27'h0123456;
    for (int k = 0; k < 20; k++) begin
      step();
      if (dram_ren || dram_wen || m0_ack) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL calib_hold: command or ack seen, expected none"); end
    dram_init_calib_complete = 1'b1;
    step();
    checks++;
    if (dram_ren !== 1'b0) begin errors++; $display("FAIL calib_plus1: dram_ren=%b expected 0", dram_ren); end
    step();
    checks++;
    if (dram_ren !== 1'b1 || dram_addr !== 27'h0123456) begin
      errors++;
      $display("FAIL calib_plus2: dram_ren=%b addr=%h expected 1 / 0123456", dram_ren, dram_addr);
    end
    step();
    checks++;
    if (m0_ack !== 1'b1 || dram_ren !== 1'b0) begin
      errors++;
      $display("FAIL calib_ack: m0_ack=%b dram_ren=%b expected 1/0", m0_ack, dram_ren);
    end
    m0_ren = 1'b0;
    dram_rdata = {4{32'hCAFE_0001}};
    dram_rdata_valid = 1'b1;
    step();
    dram_rdata_valid = 1'b0;
    checks++;
    if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0 || m0_rdata !== {4{32'hCAFE_0001}}) begin
      errors++;
      $display("FAIL calib_rdata: m0_rvalid=%b m1_rvalid=%b m0_rdata=%h expected 1/0/cafe0001x4",
               m0_rvalid, m1_rvalid, m0_rdata);
    end
    step();
    checks++;
    if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL calib_rvalid_pulse: m0_rvalid=%b expected 0", m0_rvalid); end
  endtask

  task automatic test_write();
    do_reset();
    m0_wen = 1'b1;
    m0_addr = 27'h0000100;
    m0_wdata = {16{8'hA5}};
    m0_wmask = 16'hFFFF;
    step();
    checks++;
    if (dram_wen !== 1'b1 || dram_ren !== 1'b0 || dram_addr !== 27'h0000100 ||
        dram_wdata !== {16{8'hA5}} || dram_wmask !== 16'hFFFF || m0_ack !== 1'b0) begin
      errors++;
      $display("FAIL write_cmd: wen=%b ren=%b addr=%h wdata=%h wmask=%h ack=%b expected 1/0/100/a5../ffff/0",
               dram_wen, dram_ren, dram_addr, dram_wdata, dram_wmask, m0_ack);
    end
    step();
    checks++;
    if (m0_ack !== 1'b1 || m1_ack !== 1'b0 || dram_wen !== 1'b0) begin
      errors++;
      $display("FAIL write_ack: m0_ack=%b m1_ack=%b wen=%b expected 1/0/0", m0_ack, m1_ack, dram_wen);
    end
    m0_wen = 1'b0;
    // Stray read data while idle must not reach any port.
    dram_rdata_valid = 1'b1;
    step();
    dram_rdata_valid = 1'b0;
    checks++;
    if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 || m0_ack !== 1'b0) begin
      errors++;
      $display("FAIL write_stray_valid: m0_rvalid=%b m1_rvalid=%b m0_ack=%b expected 0/0/0",
               m0_rvalid, m1_rvalid, m0_ack);
    end
    // Both ren and wen on one port: write wins.
    m1_ren = 1'b1;
    m1_wen = 1'b1;
    m1_addr = 27'h4000ABC;
    step();
    checks++;
    if (dram_wen !== 1'b1 || dram_ren !== 1'b0 || dram_addr !== 27'h4000ABC) begin
      errors++;
      $display("FAIL write_wins: wen=%b ren=%b addr=%h expected 1/0/4000abc", dram_wen, dram_ren, dram_addr);
    end
    step();
    checks++;
    if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin
      errors++;
      $display("FAIL write_wins_ack: m1_ack=%b m0_ack=%b expected 1/0", m1_ack, m0_ack);
    end
    m1_ren = 1'b0;
    m1_wen = 1'b0;
  endtask

  task automatic test_alternate();
    bit ok;
    bit exp_port = 1'b0;
    logic [DATA_W-1:0] prev0, prev1, pat;
    do_reset();
    prev0 = m0_rdata;
    prev1 = m1_rdata;
    m0_addr = 27'h0000A00;
    m1_addr = 27'h0000B00;
    m0_ren = 1'b1;
    m1_ren = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_cmd(ok);
      checks++;
      if (!ok || dram_ren !== 1'b1 || dram_addr !== (exp_port ? 27'h0000B00 : 27'h0000A00)) begin
        errors++;
        $display("FAIL alt_grant%0d: seen=%b ren=%b addr=%h expected port %0d", i, ok, dram_ren, dram_addr, exp_port);
      end
      step();
      checks++;
      if (m0_ack !== !exp_port || m1_ack !== exp_port) begin
        errors++;
        $display("FAIL alt_ack%0d: m0_ack=%b m1_ack=%b expected port %0d", i, m0_ack, m1_ack, exp_port);
      end
      repeat (4) step();
      pat = {4{32'hD000_0000 + 32'(i)}};
      dram_rdata = pat;
      dram_rdata_valid = 1'b1;
      step();
      dram_rdata_valid = 1'b0;
      if (exp_port) prev1 = pat; else prev0 = pat;
      checks++;
      if (m0_rvalid !== !exp_port || m1_rvalid !== exp_port || m0_rdata !== prev0 || m1_rdata !== prev1) begin
        errors++;
        $display("FAIL alt_rdata%0d: rvalid0=%b rvalid1=%b rdata0=%h rdata1=%h expected port %0d rdata0=%h rdata1=%h",
                 i, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, exp_port, prev0, prev1);
      end
      exp_port = ~exp_port;
    end
    m0_ren = 1'b0;
    m1_ren = 1'b0;
  endtask

  task automatic test_busy();
    bit ok;
    bit bad = 1'b0;
    do_reset();
    dram_busy = 1'b1;
    m1_addr = 27'h1234567;
    m1_ren = 1'b1;
    wait_cmd(ok);
    for (int k = 0; k < 7; k++) begin
      if (dram_ren !== 1'b1 || dram_addr !== 27'h1234567 || m1_ack !== 1'b0) bad = 1'b1;
      if (k < 6) step();
    end
    checks++;
    if (!ok || bad) begin errors++; $display("FAIL busy_hold: seen=%b unstable=%b expected 1/0", ok, bad); end
    dram_busy = 1'b0;
    step();
    checks++;
    if (m1_ack !== 1'b1 || dram_ren !== 1'b0) begin
      errors++;
      $display("FAIL busy_ack: m1_ack=%b dram_ren=%b expected 1/0", m1_ack, dram_ren);
    end
    m1_ren = 1'b0;
    dram_rdata = {4{32'h0BAD_F00D}};
    dram_rdata_valid = 1'b1;
    step();
    dram_rdata_valid = 1'b0;
    checks++;
    if (m1_rvalid !== 1'b1 || m1_rdata !== {4{32'h0BAD_F00D}}) begin
      errors++;
      $display("FAIL busy_rdata: m1_rvalid=%b m1_rdata=%h expected 1/0badf00dx4", m1_rvalid, m1_rdata);
    end
  endtask

  task automatic test_reset_rd_wait();
    bit ok;
    bit bad = 1'b0;
    do_reset();
    m0_addr = 27'h0000C00;
    m0_ren = 1'b1;
    wait_cmd(ok);
    step();
    checks++;
    if (!ok || m0_ack !== 1'b1) begin errors++; $display("FAIL rst_rd_ack: seen=%b m0_ack=%b expected 1/1", ok, m0_ack); end
    m0_ren = 1'b0;
    dram_rstx_async = 1'b0;
    #1;
    checks++;
    if ({m0_ack, m1_ack, m0_rvalid, m1_rvalid, rd_err, dram_ren, dram_wen} !== 7'b0 || dram_addr !== '0) begin
      errors++;
      $display("FAIL rst_rd_async: outputs=%b addr=%h expected 0",
               {m0_ack, m1_ack, m0_rvalid, m1_rvalid, rd_err, dram_ren, dram_wen}, dram_addr);
    end
    dram_init_calib_complete = 1'b0;
    m1_addr = 27'h0000D00;
    m0_ren = 1'b1;
    m1_ren = 1'b1;
    step();
    dram_rstx_async = 1'b1;
    for (int k = 0; k < 3; k++) begin
      dram_rdata_valid = (k == 1);
      step();
      if (dram_ren || dram_wen || m0_rvalid || m1_rvalid) bad = 1'b1;
    end
    dram_rdata_valid = 1'b0;
    checks++;
    if (bad) begin errors++; $display("FAIL rst_rd_calib: command or rvalid seen, expected none"); end
    dram_init_calib_complete = 1'b1;
    step();
    step();
    checks++;
    if (dram_ren !== 1'b1 || dram_addr !== 27'h0000C00) begin
      errors++;
      $display("FAIL rst_rd_priority: ren=%b addr=%h expected 1/0000c00", dram_ren, dram_addr);
    end
    step();
    m0_ren = 1'b0;
    m1_ren = 1'b0;
    dram_rdata_valid = 1'b1;
    step();
    dram_rdata_valid = 1'b0;
  endtask

`ifdef DRAM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    do_reset();
    m1_addr = 27'h0000E00;
    m1_ren = 1'b1;
    wait_cmd(ok);
    step();
    m1_ren = 1'b0;
    dram_rdata = {4{32'h1111_2222}};
    dram_rdata_valid = 1'b1;
    step();
    dram_rdata_valid = 1'b0;
    m1_ren = 1'b1;
    wait_cmd(ok);
    step();
    checks++;
    if (!ok || m1_ack !== 1'b1 || m1_rdata !== {4{32'h1111_2222}}) begin
      errors++;
      $display("FAIL to_setup: seen=%b m1_ack=%b m1_rdata=%h expected 1/1/11112222x4", ok, m1_ack, m1_rdata);
    end
    m1_ren = 1'b0;
    repeat (15) step();
    checks++;
    if (m1_rvalid !== 1'b0 || rd_err !== 1'b0) begin
      errors++;
      $display("FAIL to_early: m1_rvalid=%b rd_err=%b expected 0/0", m1_rvalid, rd_err);
    end
    step();
    checks++;
    if (m1_rvalid !== 1'b1 || rd_err !== 1'b1 || m1_rdata !== '0 || m0_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL to_fire: m1_rvalid=%b rd_err=%b m1_rdata=%h m0_rvalid=%b expected 1/1/0/0",
               m1_rvalid, rd_err, m1_rdata, m0_rvalid);
    end
    dram_rdata_valid = 1'b1;
    step();
    dram_rdata_valid = 1'b0;
    checks++;
    if (m1_rvalid !== 1'b0 || rd_err !== 1'b0) begin
      errors++;
      $display("FAIL to_stray: m1_rvalid=%b rd_err=%b expected 0/0", m1_rvalid, rd_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_calib();
    test_write();
    test_alternate();
    test_busy();
    test_reset_rd_wait();
`ifdef DRAM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
